// File: rtl/regfile_write_arbiter_if.sv
// Writeback request channels (ALU and load) plus the register-clear handshake.
// The master side is the requester/control logic; the slave side is the arbiter.
interface regfile_write_arbiter_if #(
    parameter int AW     = 5,
    parameter int DATA_W = 32
);
    logic              REQ0_VALID;
    logic [AW-1:0]     REQ0_ADDR;
    logic [DATA_W-1:0] REQ0_DATA;
    logic              REQ0_READY;
    logic              REQ1_VALID;
    logic [AW-1:0]     REQ1_ADDR;
    logic [DATA_W-1:0] REQ1_DATA;
    logic              REQ1_READY;
    logic              CLR_REQ;
    logic              CLR_BUSY;

    modport master (
        output REQ0_VALID, REQ0_ADDR, REQ0_DATA,
        output REQ1_VALID, REQ1_ADDR, REQ1_DATA,
        output CLR_REQ,
        input  REQ0_READY, REQ1_READY, CLR_BUSY
    );

    modport slave (
        input  REQ0_VALID, REQ0_ADDR, REQ0_DATA,
        input  REQ1_VALID, REQ1_ADDR, REQ1_DATA,
        input  CLR_REQ,
        output REQ0_READY, REQ1_READY, CLR_BUSY
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for the single register-file write port,
// with a clear sequence that zeroes registers 1..NREG-1, one per cycle.
module regfile_write_arbiter #(
    parameter int NREG   = 32,
    parameter int DATA_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    regfile_write_arbiter_if.slave bus,
    output logic                  WE3,
    output logic [4:0]            A3,
    output logic [DATA_W-1:0]     WD3
);
    localparam int AW = 5;
    localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              we3_q, we3_d;
    logic [AW-1:0]     a3_q, a3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;

    logic              pick1;
    logic              arb_open;
    logic              rdy0;
    logic              rdy1;
    logic              xfer;
    logic [AW-1:0]     sel_addr;
    logic [DATA_W-1:0] sel_data;

    // last_gnt_q holds the index of the requester that won the previous transfer.
    always_comb begin
        pick1    = (bus.REQ0_VALID && bus.REQ1_VALID) ? ~last_gnt_q : bus.REQ1_VALID;
        arb_open = (state_q == ARB) && !bus.CLR_REQ && !RST;
        rdy0     = arb_open && bus.REQ0_VALID && !pick1;
        rdy1     = arb_open && bus.REQ1_VALID &&  pick1;
        xfer     = rdy0 || rdy1;
        sel_addr = pick1 ? bus.REQ1_ADDR : bus.REQ0_ADDR;
        sel_data = pick1 ? bus.REQ1_DATA : bus.REQ0_DATA;
    end

    assign bus.REQ0_READY = rdy0;
    assign bus.REQ1_READY = rdy1;
    assign bus.CLR_BUSY   = (state_q == CLEAR);

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        we3_d      = 1'b0;
        a3_d       = a3_q;
        wd3_d      = wd3_q;
        unique case (state_q)
            ARB: begin
                if (bus.CLR_REQ) begin
                    state_d = CLEAR;
                    cnt_d   = AW'(1);
                end else if (xfer) begin
                    last_gnt_d = pick1;
                    // x0 is hardwired zero: the transfer completes but the write is dropped.
                    we3_d      = (sel_addr != '0);
                    a3_d       = sel_addr;
                    wd3_d      = sel_data;
                end
            end
            CLEAR: begin
                we3_d = 1'b1;
                a3_d  = cnt_q;
                wd3_d = '0;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST_REG) begin
                    state_d = ARB;
                    cnt_d   = '0;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ARB;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
            we3_q      <= 1'b0;
            a3_q       <= '0;
            wd3_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            we3_q      <= we3_d;
            a3_q       <= a3_d;
            wd3_q      <= wd3_d;
        end
    end

    assign WE3 = we3_q;
    assign A3  = a3_q;
    assign WD3 = wd3_q;

    a_one_ready: assert property (@(posedge CLK) disable iff (RST) !(rdy0 && rdy1));
    a_no_x0_write: assert property (@(posedge CLK) disable iff (RST) we3_q |-> (a3_q != '0));
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based model of the arbitration and clear rules.
module tb_regfile_write_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;

    int total = 0;
    int bad   = 0;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(.NREG(32), .DATA_W(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus),
        .WE3 (WE3),
        .A3  (A3),
        .WD3 (WD3)
    );

    always #5 CLK = ~CLK;

    // Model state: who won last, addresses still owed by a clear, expected write port.
    int          m_last;
    int          m_clrq[$];
    logic        m_we;
    logic [4:0]  m_a;
    logic [31:0] m_wd;
    bit          m_a_known;
    logic        e_r0, e_r1, e_busy;

    task automatic model_reset();
        m_last = 1;
        m_clrq.delete();
        m_we = 1'b0; m_a = '0; m_wd = '0; m_a_known = 1'b1;
    endtask

    task automatic model_eval();
        e_busy = (m_clrq.size() != 0);
        e_r0 = 1'b0; e_r1 = 1'b0;
        if (!e_busy && !bus.CLR_REQ) begin
            if (bus.REQ0_VALID && bus.REQ1_VALID) begin
                if (m_last == 0) e_r1 = 1'b1; else e_r0 = 1'b1;
            end else if (bus.REQ0_VALID) e_r0 = 1'b1;
            else if (bus.REQ1_VALID) e_r1 = 1'b1;
        end
    endtask

    task automatic model_commit();
        logic [4:0]  ad;
        logic [31:0] dd;
        if (e_busy) begin
            m_we = 1'b1; m_a = 5'(m_clrq.pop_front()); m_wd = '0; m_a_known = 1'b1;
        end else if (bus.CLR_REQ) begin
            for (int r = 1; r < 32; r++) m_clrq.push_back(r);
            m_we = 1'b0;
        end else if (e_r0 || e_r1) begin
            ad = e_r0 ? bus.REQ0_ADDR : bus.REQ1_ADDR;
            dd = e_r0 ? bus.REQ0_DATA : bus.REQ1_DATA;
            m_last = e_r0 ? 0 : 1;
            if (ad == 0) begin
                m_we = 1'b0; m_a_known = 1'b0;
            end else begin
                m_we = 1'b1; m_a = ad; m_wd = dd; m_a_known = 1'b1;
            end
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic clr);
        bus.REQ0_VALID = v0; bus.REQ0_ADDR = a0; bus.REQ0_DATA = d0;
        bus.REQ1_VALID = v1; bus.REQ1_ADDR = a1; bus.REQ1_DATA = d1;
        bus.CLR_REQ = clr;
    endtask

    task automatic pre();
        #1;
        model_eval();
    endtask

    task automatic post();
        @(posedge CLK);
        model_commit();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0);
        #2 RST = 1'b1;
        #1;
        total++; if (WE3 !== 1'b0) begin bad++; $display("FAIL reset_we3 got=%b exp=0", WE3); end
        total++; if (A3 !== 5'd0) begin bad++; $display("FAIL reset_a3 got=%0d exp=0", A3); end
        total++; if (WD3 !== 32'd0) begin bad++; $display("FAIL reset_wd3 got=%h exp=0", WD3); end
        total++; if (bus.CLR_BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.CLR_BUSY); end
        total++; if (bus.REQ0_READY !== 1'b0 || bus.REQ1_READY !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b%b exp=00", bus.REQ0_READY, bus.REQ1_READY); end
        @(posedge CLK); #1;
        total++; if (WE3 !== 1'b0) begin bad++; $display("FAIL reset_we3_edge got=%b exp=0", WE3); end
        @(negedge CLK);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_contention();
        int g[4];
        int wes = 0;
        logic [31:0] d0 = 32'h1000, d1 = 32'h2000;
        for (int k = 0; k < 5; k++) begin
            drive(k < 4, 5'd2, d0, k < 4, 5'd3, d1, 1'b0);
            pre();
            if (k < 4) g[k] = bus.REQ1_READY ? 1 : (bus.REQ0_READY ? 0 : -1);
            if (k >= 1 && WE3 === 1'b1) wes++;
            total++; if ({bus.REQ0_READY, bus.REQ1_READY} !== {e_r0, e_r1}) begin
                bad++; $display("FAIL cont_ready k=%0d got=%b%b exp=%b%b", k, bus.REQ0_READY, bus.REQ1_READY, e_r0, e_r1); end
            total++; if ({WE3, A3, WD3} !== {m_we, m_a, m_wd}) begin
                bad++; $display("FAIL cont_write k=%0d got=%b/%0d/%h exp=%b/%0d/%h", k, WE3, A3, WD3, m_we, m_a, m_wd); end
            post();
            if (e_r0) d0++;
            if (e_r1) d1++;
        end
        for (int k = 0; k < 4; k++) begin
            total++; if (g[k] != (k % 2)) begin bad++; $display("FAIL cont_grant k=%0d got=%0d exp=%0d", k, g[k], k % 2); end
        end
        total++; if (wes != 4) begin bad++; $display("FAIL cont_we_count got=%0d exp=4", wes); end
    endtask

    task automatic test_single();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd9, 32'h0, 1'b0);
        pre();
        total++; if (bus.REQ0_READY !== 1'b1 || bus.REQ1_READY !== 1'b0) begin
            bad++; $display("FAIL single_ready got=%b%b exp=10", bus.REQ0_READY, bus.REQ1_READY); end
        post();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        pre();
        total++; if ({WE3, A3, WD3} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            bad++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", WE3, A3, WD3); end
        post();
        pre();
        total++; if ({WE3, A3, WD3} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            bad++; $display("FAIL single_idle got=%b/%0d/%h exp=0/5/deadbeef", WE3, A3, WD3); end
        post();
    endtask

    task automatic test_x0_drop();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0);
        pre();
        total++; if (bus.REQ1_READY !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b exp=1", bus.REQ1_READY); end
        post();
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77, 1'b0);
        pre();
        total++; if (WE3 !== 1'b0) begin bad++; $display("FAIL x0_we3 got=%b exp=0", WE3); end
        total++; if (bus.REQ0_READY !== 1'b1 || bus.REQ1_READY !== 1'b0) begin
            bad++; $display("FAIL x0_next_grant got=%b%b exp=10", bus.REQ0_READY, bus.REQ1_READY); end
        post();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0);
        pre();
        total++; if (bus.REQ1_READY !== 1'b1) begin bad++; $display("FAIL x0_req1_after got=%b exp=1", bus.REQ1_READY); end
        total++; if ({WE3, A3, WD3} !== {1'b1, 5'd6, 32'h66}) begin
            bad++; $display("FAIL x0_req0_write got=%b/%0d/%h exp=1/6/66", WE3, A3, WD3); end
        post();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        pre();
        post();
    endtask

    // Pulses CLR_REQ with REQ0 pending; optional second pulse at cycle rep_at.
    task automatic run_clear(input string nm, input int rep_at, input logic with_req);
        int  busy_n = 0;
        bit  pend = with_req;
        bit  acc = 1'b0;
        drive(with_req, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b1);
        pre();
        total++; if (bus.REQ0_READY !== 1'b0 || bus.REQ1_READY !== 1'b0) begin
            bad++; $display("FAIL %s_pulse_ready got=%b%b exp=00", nm, bus.REQ0_READY, bus.REQ1_READY); end
        post();
        for (int i = 1; i <= 34; i++) begin
            drive(pend, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, i == rep_at);
            pre();
            if (bus.CLR_BUSY === 1'b1) busy_n++;
            if (i >= 2 && i <= 32) begin
                total++; if ({WE3, A3, WD3} !== {1'b1, 5'(i - 1), 32'd0}) begin
                    bad++; $display("FAIL %s_clr_write i=%0d got=%b/%0d/%h exp=1/%0d/0", nm, i, WE3, A3, WD3, i - 1); end
            end
            total++; if ({bus.REQ0_READY, bus.REQ1_READY, bus.CLR_BUSY} !== {e_r0, e_r1, e_busy}) begin
                bad++; $display("FAIL %s_ctl i=%0d got=%b%b%b exp=%b%b%b", nm, i, bus.REQ0_READY, bus.REQ1_READY,
                                bus.CLR_BUSY, e_r0, e_r1, e_busy); end
            total++; if (WE3 !== m_we || (m_a_known && {A3, WD3} !== {m_a, m_wd})) begin
                bad++; $display("FAIL %s_model_write i=%0d got=%b/%0d/%h exp=%b/%0d/%h", nm, i, WE3, A3, WD3, m_we, m_a, m_wd); end
            post();
            if (e_r0) begin pend = 1'b0; acc = 1'b1; end
        end
        total++; if (busy_n != 31) begin bad++; $display("FAIL %s_busy_len got=%0d exp=31", nm, busy_n); end
        if (with_req) begin
            total++; if (acc !== 1'b1) begin bad++; $display("FAIL %s_req_after got=%b exp=1", nm, acc); end
        end
    endtask

    task automatic test_clear();
        run_clear("clear", 0, 1'b1);
    endtask

    task automatic test_clear_repeat();
        run_clear("clrrep", 10, 1'b0);
    endtask

    task automatic test_reset_abort();
        bit hit = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        pre(); post();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 40 && !hit; i++) begin
            pre();
            if (m_we && m_a == 5'd10) hit = 1'b1;
            else post();
        end
        total++; if (!hit || WE3 !== 1'b1 || A3 !== 5'd10) begin
            bad++; $display("FAIL abort_reach got=%b/%0d exp=1/10", WE3, A3); end
        #2 RST = 1'b1;
        #1;
        total++; if (WE3 !== 1'b0 || bus.CLR_BUSY !== 1'b0) begin
            bad++; $display("FAIL abort_immediate got=we%b busy%b exp=we0 busy0", WE3, bus.CLR_BUSY); end
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            pre();
            total++; if (WE3 !== 1'b0 || bus.CLR_BUSY !== 1'b0) begin
                bad++; $display("FAIL abort_after i=%0d got=we%b busy%b exp=we0 busy0", i, WE3, bus.CLR_BUSY); end
            post();
        end
    endtask

    task automatic test_random();
        logic        rv0 = 1'b0, rv1 = 1'b0;
        logic [4:0]  ra0 = '0, ra1 = '0;
        logic [31:0] rd0 = '0, rd1 = '0;
        for (int i = 0; i < 600; i++) begin
            drive(rv0, ra0, rd0, rv1, ra1, rd1, $urandom_range(0, 59) == 0);
            pre();
            total++; if ({bus.REQ0_READY, bus.REQ1_READY, bus.CLR_BUSY} !== {e_r0, e_r1, e_busy}) begin
                bad++; $display("FAIL rand_ctl i=%0d got=%b%b%b exp=%b%b%b", i, bus.REQ0_READY, bus.REQ1_READY,
                                bus.CLR_BUSY, e_r0, e_r1, e_busy); end
            total++; if (WE3 !== m_we || (m_a_known && {A3, WD3} !== {m_a, m_wd})) begin
                bad++; $display("FAIL rand_write i=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, WE3, A3, WD3, m_we, m_a, m_wd); end
            post();
            if (e_r0) rv0 = 1'b0;
            if (e_r1) rv1 = 1'b0;
            if (!rv0 && $urandom_range(0, 2) == 0) begin
                rv0 = 1'b1; ra0 = 5'($urandom_range(0, 31)); rd0 = $urandom;
            end
            if (!rv1 && $urandom_range(0, 2) == 0) begin
                rv1 = 1'b1; ra1 = 5'($urandom_range(0, 31)); rd1 = $urandom;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_contention();
        test_single();
        test_x0_drop();
        test_clear();
        test_clear_repeat();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
